// File: rtl/instr_encoder_stream.sv
// ---------------------------------------------------------------------------
// instr_encoder_stream
//
// Purpose:
//   Builds MIPS-I instruction words from an op index plus register and
//   immediate fields, buffers them in a FIFO, and streams them out together
//   with their word addresses. The address of the first word is BASE_ADDR.
//   Test harnesses use it to feed instruction RAM or the fetch stage.
//
// Handshake (both sides):
//   A transfer happens on a rising edge where valid and ready are both high.
//   A producer that raises valid holds valid and its payload steady until
//   that transfer. ready may rise or fall at any time and never depends
//   combinationally on valid.
//
// Ports:
//   clk        in   1   clock; every state update is on the rising edge
//   rst        in   1   synchronous, active-high reset
//   in_valid   in   1   encode request present
//   in_ready   out  1   encoder can accept a request
//   in_op      in   6   op index (0..38 legal, 39..63 illegal)
//   in_rs      in   5   rs / base register
//   in_rt      in   5   rt register
//   in_rd      in   5   rd register
//   in_sa      in   5   shift amount
//   in_imm     in  26   imm16 in [15:0]; J/JAL target in [25:0]
//   out_valid  out  1   encoded word available
//   out_ready  in   1   consumer takes the word
//   out_data   out 32   encoded instruction
//   out_addr   out 32   address of out_data
//   err_cnt    out  8   count of illegal ops, saturating at 255
// ---------------------------------------------------------------------------
module instr_encoder_stream #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] BASE_ADDR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_sa,
    input  logic [25:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [31:0] out_addr,
    output logic [7:0]  err_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // -----------------------------------------------------------------------
    // Encoder. Fields that an op does not use are written as zero, so the
    // request inputs for those fields are simply not referenced.
    // -----------------------------------------------------------------------
    logic [31:0] w_word;
    logic        w_legal;
    logic [15:0] w_imm16;

    assign w_imm16 = in_imm[15:0];

    always_comb begin
        w_word  = 32'h0;
        w_legal = 1'b1;
        case (in_op)
            // R-type, three-register ALU ops (sa forced to 0)
            6'd0:  w_word = 32'h0000_0000;
            6'd1:  w_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h21};
            6'd2:  w_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h23};
            6'd3:  w_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h24};
            6'd4:  w_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h25};
            6'd5:  w_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h26};
            6'd6:  w_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h27};
            6'd7:  w_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h2A};
            6'd8:  w_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h2B};
            // Immediate shifts: rs field is zero, sa carries the amount
            6'd9:  w_word = {6'h00, 5'd0, in_rt, in_rd, in_sa, 6'h00};
            6'd10: w_word = {6'h00, 5'd0, in_rt, in_rd, in_sa, 6'h02};
            6'd11: w_word = {6'h00, 5'd0, in_rt, in_rd, in_sa, 6'h03};
            // Register jumps
            6'd12: w_word = {6'h00, in_rs, 5'd0, 5'd0, 5'd0, 6'h08};
            6'd13: w_word = {6'h00, in_rs, 5'd0, in_rd, 5'd0, 6'h09};
            // HI/LO producers and consumers
            6'd14: w_word = {6'h00, in_rs, in_rt, 5'd0, 5'd0, 6'h18};
            6'd15: w_word = {6'h00, in_rs, in_rt, 5'd0, 5'd0, 6'h1A};
            6'd16: w_word = {6'h00, 5'd0, 5'd0, in_rd, 5'd0, 6'h10};
            6'd17: w_word = {6'h00, 5'd0, 5'd0, in_rd, 5'd0, 6'h12};
            // Traps, code field left at zero
            6'd18: w_word = {6'h00, 20'd0, 6'h0C};
            6'd19: w_word = {6'h00, 20'd0, 6'h0D};
            // I-type
            6'd20: w_word = {6'h09, in_rs, in_rt, w_imm16};
            6'd21: w_word = {6'h0C, in_rs, in_rt, w_imm16};
            6'd22: w_word = {6'h0D, in_rs, in_rt, w_imm16};
            6'd23: w_word = {6'h0E, in_rs, in_rt, w_imm16};
            6'd24: w_word = {6'h0F, 5'd0,  in_rt, w_imm16};
            6'd25: w_word = {6'h0A, in_rs, in_rt, w_imm16};
            6'd26: w_word = {6'h23, in_rs, in_rt, w_imm16};
            6'd27: w_word = {6'h2B, in_rs, in_rt, w_imm16};
            6'd28: w_word = {6'h20, in_rs, in_rt, w_imm16};
            6'd29: w_word = {6'h28, in_rs, in_rt, w_imm16};
            6'd30: w_word = {6'h04, in_rs, in_rt, w_imm16};
            6'd31: w_word = {6'h05, in_rs, in_rt, w_imm16};
            // REGIMM: the rt field selects the branch condition
            6'd32: w_word = {6'h01, in_rs, 5'h01, w_imm16};
            6'd33: w_word = {6'h01, in_rs, 5'h00, w_imm16};
            // J-type
            6'd34: w_word = {6'h02, in_imm};
            6'd35: w_word = {6'h03, in_imm};
            // COP0
            6'd36: w_word = 32'h4200_0018;
            6'd37: w_word = {6'h10, 5'h00, in_rt, in_rd, 11'd0};
            6'd38: w_word = {6'h10, 5'h04, in_rt, in_rd, 11'd0};
            default: begin
                w_word  = 32'h0;
                w_legal = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Stage 1 register. It always empties on the edge after it is loaded, so
    // a new request can be taken in the same cycle the old one moves on.
    // -----------------------------------------------------------------------
    logic        r_s1_valid;
    logic        r_s1_legal;
    logic [31:0] r_s1_word;

    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [31:0]   r_mem [DEPTH];
    logic [31:0]   r_addr;
    logic [7:0]    r_err;

    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic [CW:0]   w_occupancy;

    // Occupancy counts the word still in stage 1, so every accepted request
    // is guaranteed a FIFO slot. A pop in the same cycle is not credited.
    assign w_occupancy = {1'b0, r_count} + {{CW{1'b0}}, r_s1_valid};
    assign in_ready    = (w_occupancy < (CW + 1)'(DEPTH));

    assign w_accept = in_valid & in_ready;
    assign w_push   = r_s1_valid & r_s1_legal;
    assign w_pop    = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_legal <= 1'b0;
            r_s1_word  <= 32'h0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_legal <= w_legal;
                r_s1_word  <= w_word;
            end
        end
    end

    // Illegal ops are counted as they leave stage 1 instead of being written.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 8'd0;
        end else if (r_s1_valid && !r_s1_legal && (r_err != 8'hFF)) begin
            r_err <= r_err + 8'd1;
        end
    end

    // -----------------------------------------------------------------------
    // FIFO: circular pointers plus an explicit count. DEPTH is a power of two,
    // so the pointers wrap naturally.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_s1_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Each popped word consumes one address; dropped ops never reach here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= BASE_ADDR;
        end else if (w_pop) begin
            r_addr <= r_addr + 32'd4;
        end
    end

    assign out_valid = (r_count != '0);
    // Stale RAM contents are hidden while empty so out_data reads 0 after reset.
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : 32'h0;
    assign out_addr  = r_addr;
    assign err_cnt   = r_err;

    // The in_ready rule makes these impossible; catch any regression early.
    a_no_push_full : assert property (@(posedge clk) disable iff (rst)
        !(w_push && (r_count == CW'(DEPTH))));
    a_no_pop_empty : assert property (@(posedge clk) disable iff (rst)
        !(w_pop && (r_count == '0)));

endmodule

// File: tb/tb_instr_encoder_stream.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder_stream
//
// Directed bench for instr_encoder_stream. Inputs are driven and outputs are
// sampled on the falling edge; the DUT updates on the rising edge.
// ---------------------------------------------------------------------------
module tb_instr_encoder_stream;

    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'hBFC00000;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_op = '0;
    logic [4:0]  in_rs = '0;
    logic [4:0]  in_rt = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_sa = '0;
    logic [25:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [31:0] out_addr;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    instr_encoder_stream #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_sa     (in_sa),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .err_cnt   (err_cnt)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called on a falling edge; returns on the falling edge after the accept.
    task automatic send(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sa, input logic [25:0] imm);
        int cnt;
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_sa = sa; in_imm = imm;
        in_valid = 1'b1;
        cnt = 0;
        while (!in_ready && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check_eq("send_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Waits (bounded) for a word, checks it against the hand-computed values, pops it.
    task automatic recv(input string tag, input logic [31:0] exp_data, input logic [31:0] exp_addr);
        int cnt;
        cnt = 0;
        while (!out_valid && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_data"}, out_data, exp_data);
        check_eq({tag, "_addr"}, out_addr, exp_addr);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // Drains exp_q; addresses restart at BASE after every reset.
    task automatic drain(input string tag);
        logic [31:0] a;
        a = BASE;
        while (exp_q.size() != 0) begin
            recv(tag, exp_q.pop_front(), a);
            a = a + 32'd4;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Watchdog so the bench can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int acc;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", out_data, 32'h0);
        check_eq("rst_out_addr", out_addr, BASE);
        check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);

        // Test 1: ADDU with sa ignored, 2-cycle latency
        send(6'd1, 5'd1, 5'd2, 5'd3, 5'd7, 26'd0);
        check_eq("t1_valid_early", 32'(out_valid), 32'd0);
        @(negedge clk);
        check_eq("t1_valid_lat", 32'(out_valid), 32'd1);
        recv("t1", 32'h00221821, BASE);

        // Test 2: ORI, LUI (rs zeroed), J
        do_reset();
        send(6'd22, 5'd0, 5'd4, 5'd0, 5'd0, 26'h1234);
        send(6'd24, 5'd9, 5'd1, 5'd0, 5'd0, 26'h8000);
        send(6'd34, 5'd0, 5'd0, 5'd0, 5'd0, 26'h100000);
        exp_q.push_back(32'h34041234);
        exp_q.push_back(32'h3C018000);
        exp_q.push_back(32'h08100000);
        drain("t2");

        // Test 3: COP0, REGIMM, shift/jump field masking
        do_reset();
        send(6'd36, 5'd7, 5'd7, 5'd7, 5'd7, 26'h3FFFFFF);
        send(6'd38, 5'd0, 5'd5, 5'd12, 5'd0, 26'd0);
        send(6'd32, 5'd3, 5'd9, 5'd0, 5'd0, 26'hFFFE);
        send(6'd9,  5'd5, 5'd2, 5'd3, 5'd4, 26'd0);
        send(6'd12, 5'd31, 5'd7, 5'd9, 5'd1, 26'd0);
        send(6'd35, 5'd0, 5'd0, 5'd0, 5'd0, 26'h3FFFFFF);
        send(6'd33, 5'd2, 5'd1, 5'd0, 5'd0, 26'h0008);
        send(6'd37, 5'd4, 5'd3, 5'd12, 5'd0, 26'd0);
        exp_q.push_back(32'h42000018);
        exp_q.push_back(32'h40856000);
        exp_q.push_back(32'h0461FFFE);
        exp_q.push_back(32'h00021900);
        exp_q.push_back(32'h03E00008);
        exp_q.push_back(32'h0FFFFFFF);
        exp_q.push_back(32'h04400008);
        exp_q.push_back(32'h40036000);
        drain("t3");

        // Test 4: fill with out_ready low, then drain in order
        do_reset();
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            in_op = 6'd22; in_rs = 5'd0; in_rd = 5'd0; in_sa = 5'd0;
            in_rt = 5'(acc);
            in_imm = 26'(acc + 32'h100);
            in_valid = 1'b1;
            if (in_ready) acc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_eq("t4_accepted", 32'(acc), 32'(DEPTH));
        check_eq("t4_in_ready_full", 32'(in_ready), 32'd0);
        check_eq("t4_head_stable", out_data, 32'h34000100);
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(32'h34000000 | (32'(i) << 16) | (32'(i) + 32'h100));
        end
        drain("t4");
        @(negedge clk);
        check_eq("t4_empty", 32'(out_valid), 32'd0);

        // Test 5: illegal op dropped between two SWs, then saturation
        do_reset();
        send(6'd27, 5'd29, 5'd8, 5'd0, 5'd0, 26'h0010);
        send(6'd50, 5'd31, 5'd31, 5'd31, 5'd31, 26'h3FFFFFF);
        send(6'd27, 5'd29, 5'd9, 5'd0, 5'd0, 26'h0014);
        exp_q.push_back(32'hAFA80010);
        exp_q.push_back(32'hAFA90014);
        drain("t5");
        check_eq("t5_err_one", 32'(err_cnt), 32'd1);
        repeat (2) @(negedge clk);
        check_eq("t5_no_extra", 32'(out_valid), 32'd0);
        for (int i = 0; i < 260; i++) begin
            send(6'(39 + (i % 25)), 5'd1, 5'd2, 5'd3, 5'd4, 26'h1);
        end
        repeat (2) @(negedge clk);
        check_eq("t5_err_sat", 32'(err_cnt), 32'd255);
        check_eq("t5_none_out", 32'(out_valid), 32'd0);
        check_eq("t5_addr_kept", out_addr, BASE + 32'd8);

        // Test 6: reset with words queued
        do_reset();
        send(6'd1, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0);
        send(6'd2, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0);
        send(6'd40, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0);
        send(6'd3, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0);
        repeat (2) @(negedge clk);
        check_eq("t6_queued", 32'(out_valid), 32'd1);
        check_eq("t6_err_pre", 32'(err_cnt), 32'd1);
        do_reset();
        check_eq("t6_valid_after", 32'(out_valid), 32'd0);
        check_eq("t6_data_after", out_data, 32'h0);
        check_eq("t6_err_after", 32'(err_cnt), 32'd0);
        check_eq("t6_addr_after", out_addr, BASE);
        check_eq("t6_ready_after", 32'(in_ready), 32'd1);
        send(6'd5, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0);
        recv("t6", 32'h00221826, BASE);

        // ---------------- final report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
